reg_arbiter: RTL and testbench
==============================

REG_ARBITER -- requirements
Module: reg_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_MAX, default 3, the maximum number of consecutive port-0 grants while port 1 is pending.
REQ-002 The block SHALL have port clock, input, 1 bit, the single clock for all state; rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, synchronous active-high reset sampled on the rising clock edge.
REQ-004 The block SHALL have ports req0 and req1, inputs, 1 bit each: core-decoder (0) and UART-debug (1) request lines.
REQ-005 The block SHALL have ports op0 and op1 (inputs, 3 bits each) and wd0 and wd1 (inputs, 8 bits each): register-file opcode and write data per requester.
REQ-006 The block SHALL have ports gnt0 and gnt1, outputs, 1 bit each: the port owns the register file from grant until done.
REQ-007 The block SHALL have ports done0 and done1, outputs, 1 bit each: one-cycle completion pulses.
REQ-008 The block SHALL have port rdata, output, 8 bits: the captured read result, valid while done0 or done1 is high and held afterward.
REQ-009 The block SHALL have ports rf_ena (output, 1 bit), rf_opcode (output, 3 bits) and rf_data_in (output, 8 bits): drive the register file.
REQ-010 The block SHALL have port rf_data_out, input, 8 bits: the register file's registered output.

Function
REQ-011 The controller SHALL use the FSM states IDLE, ISSUE and CAPT; only state transitions and grant decisions happen on rising clock edges.
REQ-012 In IDLE with any request pending, the controller SHALL select a winner, latch its opcode and write data, set the matching gnt, and enter ISSUE.
REQ-013 In ISSUE, for exactly one cycle, the controller SHALL assert rf_ena=1 and drive rf_opcode and rf_data_in from the latched values, then enter CAPT.
REQ-014 rf_ena SHALL be 0 in every cycle other than ISSUE; rf_opcode and rf_data_in SHALL hold their latched values in all states.
REQ-015 In CAPT, the controller SHALL register rf_data_out into rdata if and only if the latched opcode is 3'b100 or 3'b101; for other opcodes rdata SHALL keep its value.
REQ-016 On leaving CAPT, the controller SHALL pulse the winner's done for one cycle, clear its gnt, and return to IDLE.
REQ-017 The fixed latency SHALL be: request seen in IDLE at edge N; rf_ena high during cycle N+1; done high during cycle N+3.
REQ-018 The arbiter SHALL accept a new request no earlier than the done cycle, because the next arbitration occurs in IDLE.
REQ-019 Port 0 SHALL have priority when both ports request in IDLE.
REQ-020 A starvation counter SHALL count consecutive port-0 grants made while req1 is high; it SHALL saturate at STARVE_MAX.
REQ-021 When the starvation counter equals STARVE_MAX and req1 is high, port 1 SHALL win; a port-1 grant, or any grant made while req1 is low, SHALL clear the counter.
REQ-022 A requester SHALL hold req, op and wd stable until its done; dropping req before grant withdraws the request, and dropping it after grant is ignored because the operation completes.
REQ-023 If req remains high in the done cycle, it SHALL be treated as a new request at the next IDLE arbitration.
REQ-024 opcodes 3'b110 and 3'b111 (NOP) SHALL be sequenced normally and SHALL NOT update rdata.

Reset
REQ-025 On reset, state SHALL go to IDLE; gnt0, gnt1, done0, done1 and rf_ena SHALL be 0; rdata, rf_opcode and rf_data_in SHALL be 8'h00/3'b000; the starvation counter SHALL be 0.
REQ-026 Reset asserted mid-operation, in ISSUE or CAPT, SHALL abort the operation with no done pulse, and rf_ena SHALL be 0 from the cycle after the reset edge.
REQ-027 Requests present while reset is high SHALL be ignored; arbitration SHALL resume on the first edge with reset low.

Configuration
REQ-028 Macro REG_ARBITER_STATS_EN, when defined, SHALL add output port grant_cnt0 and grant_cnt1 (8 bits each), wrapping counters incremented on each done of the matching port and cleared by reset.
REQ-029 When REG_ARBITER_STATS_EN is undefined, those ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 Single write: req0, op0=000, wd0=8'hA5 -> rf_ena high for one cycle with rf_data_in=A5, done0 at N+3, and rdata unchanged.
REQ-031 Write then read: port 1 writes 8'h3C with op 001, then reads with op 101 -> second done1 with rdata=8'h3C.
REQ-032 Contention: req0 and req1 held high continuously -> grant order 0,0,0,1,0,0,0,1 with STARVE_MAX=3.
REQ-033 Withdrawal: req1 pulsed for one cycle while port 0 is busy -> no gnt1 and no done1.
REQ-034 Reset in ISSUE -> the next cycle shows rf_ena=0 and all gnt/done 0, and no done pulse occurs for the aborted operation.
REQ-035 With REG_ARBITER_STATS_EN: five port-0 operations and two port-1 operations -> grant_cnt0=5, grant_cnt1=2; 256 port-0 operations -> grant_cnt0 wraps to 0.

Source files
------------

// File: rtl/reg_arbiter.sv
// reg_arbiter: two-requester arbiter that sequences one register-file operation at a time
// (IDLE -> ISSUE -> CAPT). Defining REG_ARBITER_STATS_EN adds per-port grant counters.
module reg_arbiter #(
  parameter int STARVE_MAX = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [2:0] op0,
  input  logic [2:0] op1,
  input  logic [7:0] wd0,
  input  logic [7:0] wd1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] rdata,
  output logic       rf_ena,
  output logic [2:0] rf_opcode,
  output logic [7:0] rf_data_in,
  input  logic [7:0] rf_data_out
`ifdef REG_ARBITER_STATS_EN
  ,
  output logic [7:0] grant_cnt0,
  output logic [7:0] grant_cnt1
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT} state_t;

  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] starve_cnt;
  logic          owner;
  logic [2:0]    op_q;
  logic [7:0]    wd_q;
  logic          any_req;
  logic          pick1;

  assign any_req = req0 | req1;
  // Port 1 wins when it is alone or when port 0 has used up its consecutive-grant allowance.
  assign pick1   = req1 & (~req0 | (starve_cnt == STARVE_LIM));

  assign rf_opcode  = op_q;
  assign rf_data_in = wd_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: the default assignment first keeps this block purely combinational (no latch).
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (any_req) state_next = ISSUE;
      ISSUE:   state_next = CAPT;
      CAPT:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rf_ena = (state == ISSUE);
    gnt0   = (state != IDLE) && !owner;
    gnt1   = (state != IDLE) && owner;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      owner      <= 1'b0;
      op_q       <= 3'b000;
      wd_q       <= 8'h00;
      starve_cnt <= '0;
      rdata      <= 8'h00;
      done0      <= 1'b0;
      done1      <= 1'b0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      if (state == IDLE && any_req) begin
        owner <= pick1;
        op_q  <= pick1 ? op1 : op0;
        wd_q  <= pick1 ? wd1 : wd0;
        if (pick1 || !req1)              starve_cnt <= '0;
        else if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 1'b1;
      end
      if (state == CAPT) begin
        done0 <= !owner;
        done1 <= owner;
        // Only the two read opcodes update the captured result.
        if (op_q == 3'b100 || op_q == 3'b101) rdata <= rf_data_out;
      end
    end
  end

`ifdef REG_ARBITER_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      grant_cnt0 <= 8'h00;
      grant_cnt1 <= 8'h00;
    end else if (state == CAPT) begin
      if (owner) grant_cnt1 <= grant_cnt1 + 8'd1;
      else       grant_cnt0 <= grant_cnt0 + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_reg_arbiter.sv
// tb_reg_arbiter: directed and randomized bench for reg_arbiter with a transaction-level
// reference model, a small register-file stub and a scoreboard monitor.
module tb_reg_arbiter;
  localparam int STARVE_MAX = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [2:0] op0 = 3'b000, op1 = 3'b000;
  logic [7:0] wd0 = 8'h00, wd1 = 8'h00;
  logic       gnt0, gnt1, done0, done1, rf_ena;
  logic [7:0] rdata, rf_data_in;
  logic [2:0] rf_opcode;
  logic [7:0] rf_data_out = 8'h00;
`ifdef REG_ARBITER_STATS_EN
  logic [7:0] grant_cnt0, grant_cnt1;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  reg_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1), .wd0(wd0), .wd1(wd1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .rdata(rdata),
    .rf_ena(rf_ena), .rf_opcode(rf_opcode), .rf_data_in(rf_data_in),
    .rf_data_out(rf_data_out)
`ifdef REG_ARBITER_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic fail(input string name, input string msg);
    checks++;
    errors++;
    $display("FAIL %s: %s (cycle %0d)", name, msg, cyc);
  endtask

  // Register-file stub: ops 0xx write reg[op[0]], 100/101 read reg[op[0]], others return noise.
  logic [7:0] rf_mem [2] = '{8'h00, 8'h00};
  always @(posedge clock) begin
    if (rf_ena === 1'b1) begin
      if (!rf_opcode[2]) begin
        rf_mem[rf_opcode[0]] <= rf_data_in;
        rf_data_out <= 8'($urandom);
      end else if (!rf_opcode[1]) begin
        rf_data_out <= rf_mem[rf_opcode[0]];
      end else begin
        rf_data_out <= 8'($urandom);
      end
    end
  end

  // Reference model (rising edge) and scoreboard monitor (falling edge).
  typedef struct {
    bit         port;
    logic [2:0] op;
    logic [7:0] wd;
    logic [7:0] rdata;
    int         issue_cyc;
    int         done_cyc;
  } txn_t;

  txn_t       sb[$];
  bit         done_log[$];
  int         busy = 0, starve = 0;
  bit         own0 = 1'b0, own1 = 1'b0, armed = 1'b0;
  logic [7:0] ref_mem [2] = '{8'h00, 8'h00};
  logic [7:0] ref_rdata = 8'h00, held_rdata = 8'h00, last_wd = 8'h00;
  logic [2:0] last_op = 3'b000;
  int         gcnt0 = 0, gcnt1 = 0;

  always @(posedge clock or negedge clock) begin
    txn_t t;
    bit   w1, exp_g;
    if (clock) begin
      cyc++;
      if (reset) begin
        sb.delete();
        busy = 0; starve = 0; own0 = 0; own1 = 0; armed = 1;
        ref_rdata = 8'h00; held_rdata = 8'h00; last_op = 3'b000; last_wd = 8'h00;
        gcnt0 = 0; gcnt1 = 0;
      end else if (busy > 0) begin
        busy--;
        if (busy == 0) begin own0 = 0; own1 = 0; end
      end else if (req0 || req1) begin
        w1 = req1 && (!req0 || starve >= STARVE_MAX);
        if (w1 || !req1) starve = 0;
        else if (starve < STARVE_MAX) starve++;
        t.port = w1;
        t.op   = w1 ? op1 : op0;
        t.wd   = w1 ? wd1 : wd0;
        if (!t.op[2]) ref_mem[t.op[0]] = t.wd;
        else if (!t.op[1]) ref_rdata = ref_mem[t.op[0]];
        t.rdata = ref_rdata;
        t.issue_cyc = cyc;
        t.done_cyc  = cyc + 2;
        sb.push_back(t);
        last_op = t.op; last_wd = t.wd;
        own0 = !w1; own1 = w1; busy = 2;
      end
    end else if (armed) begin
      if (done0 || done1) begin
        if (sb.size() == 0) begin
          fail("done_unexpected", $sformatf("got done0=%0b done1=%0b, required no done", done0, done1));
        end else begin
          t = sb.pop_front();
          check("done_port", {done1, done0}, t.port ? 2'b10 : 2'b01);
          check("done_cycle", cyc, t.done_cyc);
          check("done_rdata", rdata, t.rdata);
          held_rdata = t.rdata;
          if (t.port) gcnt1 = (gcnt1 + 1) % 256;
          else        gcnt0 = (gcnt0 + 1) % 256;
          done_log.push_back(t.port);
        end
      end else begin
        check("rdata_hold", rdata, held_rdata);
        if (sb.size() > 0 && cyc > sb[0].done_cyc) begin
          fail("done_timeout", $sformatf("got no done, required done%0d by cycle %0d", sb[0].port, sb[0].done_cyc));
          t = sb.pop_front();
          held_rdata = t.rdata;
        end
      end
      exp_g = (sb.size() > 0) && (cyc < sb[0].done_cyc);
      check("rf_ena", rf_ena, (sb.size() > 0) && (sb[0].issue_cyc == cyc));
      check("gnt0", gnt0, exp_g && !sb[0].port);
      check("gnt1", gnt1, exp_g && sb[0].port);
      check("rf_opcode", rf_opcode, last_op);
      check("rf_data_in", rf_data_in, last_wd);
`ifdef REG_ARBITER_STATS_EN
      check("grant_cnt0", grant_cnt0, 8'(gcnt0));
      check("grant_cnt1", grant_cnt1, 8'(gcnt1));
`endif
    end
  end

  task automatic set_req(input bit p, input logic r, input logic [2:0] op, input logic [7:0] wd);
    if (p) begin req1 = r; op1 = op; wd1 = wd; end
    else   begin req0 = r; op0 = op; wd0 = wd; end
  endtask

  // Raise a request, hold it until its done, and drop it in the done cycle.
  task automatic do_op(input bit p, input logic [2:0] op, input logic [7:0] wd);
    int n = 0;
    set_req(p, 1'b1, op, wd);
    do begin
      @(negedge clock);
      n++;
    end while (!(p ? done1 : done0) && n < 50);
    if (n >= 50) fail("op_timeout", $sformatf("got no done%0d within 50 cycles, required one", p));
    set_req(p, 1'b0, op, wd);
  endtask

  task automatic apply_reset();
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  function automatic logic [2:0] rand_op();
    if ($urandom_range(1) == 0) return {2'b10, 1'($urandom_range(1))};
    return 3'($urandom_range(7));
  endfunction

  task automatic drive_port(input bit p);
    logic r, d, own;
    r   = p ? req1 : req0;
    d   = p ? done1 : done0;
    own = p ? own1 : own0;
    if (!r) begin
      if ($urandom_range(2) == 0) set_req(p, 1'b1, rand_op(), 8'($urandom));
    end else if (d) begin
      if ($urandom_range(1) == 0) set_req(p, 1'b0, 3'b000, 8'h00);
      else                        set_req(p, 1'b1, rand_op(), 8'($urandom));
    end else if (!own && $urandom_range(7) == 0) begin
      set_req(p, 1'b0, p ? op1 : op0, p ? wd1 : wd0);
    end
  endtask

  bit exp_order [8] = '{0, 0, 0, 1, 0, 0, 0, 1};

  initial begin
    int base, n;
    // Requests raised during reset must be ignored.
    req0 = 1'b1; op0 = 3'b000; wd0 = 8'h11;
    req1 = 1'b1; op1 = 3'b001; wd1 = 8'h22;
    repeat (3) @(negedge clock);
    check("rst_gnt0", gnt0, 1'b0);
    check("rst_gnt1", gnt1, 1'b0);
    check("rst_done0", done0, 1'b0);
    check("rst_done1", done1, 1'b0);
    check("rst_rf_ena", rf_ena, 1'b0);
    check("rst_rdata", rdata, 8'h00);
    check("rst_rf_opcode", rf_opcode, 3'b000);
    check("rst_rf_data_in", rf_data_in, 8'h00);
    req1 = 1'b0;
    reset = 1'b0;
    do_op(0, 3'b000, 8'h11);

    // Single write leaves rdata untouched.
    do_op(0, 3'b000, 8'hA5);
    check("write_rdata_unchanged", rdata, 8'h00);

    // Port 1 write then read back.
    do_op(1, 3'b001, 8'h3C);
    do_op(1, 3'b101, 8'h00);
    check("read_back", rdata, 8'h3C);

    // NOP opcodes are sequenced but never update rdata.
    do_op(0, 3'b110, 8'hFF);
    do_op(1, 3'b111, 8'hFF);
    check("nop_rdata", rdata, 8'h3C);

    // One-cycle req1 pulse while port 0 is busy is withdrawn.
    req0 = 1'b1; op0 = 3'b100; wd0 = 8'h00;
    @(negedge clock);
    req1 = 1'b1; op1 = 3'b000; wd1 = 8'hEE;
    @(negedge clock);
    check("withdraw_gnt1", gnt1, 1'b0);
    req1 = 1'b0;
    @(negedge clock);
    check("withdraw_done0", done0, 1'b1);
    check("withdraw_done1", done1, 1'b0);
    check("withdraw_rdata", rdata, 8'hA5);
    req0 = 1'b0;
    repeat (4) begin
      @(negedge clock);
      check("withdraw_no_gnt1", gnt1, 1'b0);
    end

    // Continuous contention: port 1 gets every fourth grant.
    base = done_log.size();
    req0 = 1'b1; op0 = 3'b000; wd0 = 8'h01;
    req1 = 1'b1; op1 = 3'b001; wd1 = 8'h02;
    n = 0;
    do begin
      @(negedge clock);
      #1;
      n++;
    end while (done_log.size() < base + 8 && n < 100);
    req0 = 1'b0; req1 = 1'b0;
    if (done_log.size() < base + 8) fail("contention_timeout", $sformatf("got %0d grants, required 8", done_log.size() - base));
    else for (int i = 0; i < 8; i++) check($sformatf("contention_order_%0d", i), done_log[base + i], exp_order[i]);
    repeat (2) @(negedge clock);

    // Reset during ISSUE aborts with no done.
    req0 = 1'b1; op0 = 3'b000; wd0 = 8'h77;
    @(negedge clock);
    check("abort_in_issue", rf_ena, 1'b1);
    reset = 1'b1; req0 = 1'b0;
    @(negedge clock);
    check("abort_rf_ena", rf_ena, 1'b0);
    check("abort_gnt0", gnt0, 1'b0);
    check("abort_gnt1", gnt1, 1'b0);
    check("abort_done0", done0, 1'b0);
    check("abort_done1", done1, 1'b0);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clock);
      check("abort_no_done0", done0, 1'b0);
    end

    // Randomized traffic from both requesters.
    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      drive_port(0);
      drive_port(1);
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (6) @(negedge clock);

`ifdef REG_ARBITER_STATS_EN
    apply_reset();
    for (int i = 0; i < 5; i++) do_op(0, 3'b000, 8'(i));
    for (int i = 0; i < 2; i++) do_op(1, 3'b101, 8'(i));
    check("stats_cnt0", grant_cnt0, 8'd5);
    check("stats_cnt1", grant_cnt1, 8'd2);
    apply_reset();
    for (int i = 0; i < 256; i++) do_op(0, 3'b110, 8'(i));
    check("stats_wrap0", grant_cnt0, 8'd0);
    check("stats_wrap1", grant_cnt1, 8'd0);
`endif

    repeat (2) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by time %0t, required earlier finish", $time);
    $fatal(1, "simulation time limit reached");
  end

endmodule
